// File: rtl/verdict_pkg.sv
// Shared FSM state and width-derivation helpers for the verdict collector.
// The snapshot record depends on instance parameters, so its layout lives with the top.
package verdict_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/verdict_fifo.sv
// Snapshot FIFO: register storage, head always presented, push accepted on full
// when a pop happens on the same edge.
module verdict_fifo
    import verdict_pkg::*;
#(
    parameter int  WIDTH   = 8,
    parameter int  DEPTH   = 16,
    localparam int LEVEL_W = level_w(DEPTH),
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   din_i,
    input  logic               pop_i,
    output logic [WIDTH-1:0]   head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [LEVEL_W-1:0] level_o
);
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LEVEL_W-1:0] count_q;
    logic               wr_en, rd_en;

    assign full_o  = (count_q == LEVEL_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // The slot being read is freed on this edge, so a full FIFO can still take a write.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + LEVEL_W'(1);
                2'b01:   count_q <= count_q - LEVEL_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/verdict_collector.sv
// Captures active monitor outputs into a snapshot FIFO and replays them as a
// valid/ready stream, one beat per active output, in capture order.
module verdict_collector
    import verdict_pkg::*;
#(
    parameter int  NUM_OUTPUTS = 2,
    parameter int  DATA_W      = 64,
    parameter int  TS_W        = 32,
    parameter int  DEPTH       = 16,
    localparam int IDX_W       = idx_w(NUM_OUTPUTS),
    localparam int LEVEL_W     = level_w(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
    input  logic [NUM_OUTPUTS-1:0]        out_aktv,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic [IDX_W-1:0]              m_idx,
    output logic [TS_W-1:0]               m_ts,
    output logic                          m_last,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt,
    output logic [LEVEL_W-1:0]            level
);
    typedef struct packed {
        logic [TS_W-1:0]                    ts;
        logic [NUM_OUTPUTS-1:0]             aktv;
        logic [NUM_OUTPUTS-1:0][DATA_W-1:0] data;
    } snap_t;

    snap_t                  snap_in, head, snap_q, src_snap;
    logic [NUM_OUTPUTS-1:0] mask_q, rem_mask, src_mask;
    logic [TS_W-1:0]        ts_q;
    state_e                 state_q;
    logic                   push, pop, hs, last_hs, drop;
    logic                   fifo_full, fifo_empty;
    logic                   overflow_q;
    logic [15:0]            drop_cnt_q;
    logic                   m_valid_q, m_last_q;
    logic [DATA_W-1:0]      m_data_q;
    logic [IDX_W-1:0]       m_idx_q, nxt_idx;
    logic [TS_W-1:0]        m_ts_q;
    logic                   nxt_last;

    assign snap_in = {ts_q, out_aktv, out_data};
    assign push    = en & (|out_aktv);
    assign hs      = m_valid_q & m_ready;
    assign last_hs = hs & m_last_q;
    assign pop     = ~fifo_empty & ((state_q == IDLE) | last_hs);
    assign drop    = push & fifo_full & ~pop;

    verdict_fifo #(
        .WIDTH ($bits(snap_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (snap_in),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    // mask_q holds the bits still owed, including the one on the bus right now.
    always_comb begin
        rem_mask          = mask_q;
        rem_mask[m_idx_q] = 1'b0;
        src_snap          = snap_q;
        src_mask          = mask_q;
        if (last_hs) begin
            src_snap = head;
            src_mask = head.aktv;
        end else if (hs) begin
            src_mask = rem_mask;
        end
        nxt_idx = '0;
        for (int k = NUM_OUTPUTS - 1; k >= 0; k--) begin
            if (src_mask[k]) begin
                nxt_idx = IDX_W'(k);
            end
        end
        nxt_last = ((src_mask & (src_mask - NUM_OUTPUTS'(1))) == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            mask_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_idx_q   <= '0;
            m_ts_q    <= '0;
            m_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        snap_q  <= head;
                        mask_q  <= head.aktv;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    // First beat after an IDLE load, or any handshake that leaves work queued.
                    if (!m_valid_q || (hs && !(last_hs && fifo_empty))) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= src_snap.data[nxt_idx];
                        m_idx_q   <= nxt_idx;
                        m_ts_q    <= src_snap.ts;
                        m_last_q  <= nxt_last;
                        snap_q    <= src_snap;
                        mask_q    <= src_mask;
                    end else if (hs) begin
                        state_q   <= IDLE;
                        m_valid_q <= 1'b0;
                        m_data_q  <= '0;
                        m_idx_q   <= '0;
                        m_ts_q    <= '0;
                        m_last_q  <= 1'b0;
                        mask_q    <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (en) begin
                ts_q <= ts_q + TS_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_idx    = m_idx_q;
    assign m_ts     = m_ts_q;
    assign m_last   = m_last_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
